dump_cntrl: RTL and testbench

- Reader side of the sample RAM filled during capture.
- After a capture completes, `cmd_cfg` pulses `dump_en`. The block reads every RAM entry once, oldest first, starting at the write pointer where capture stopped and wrapping modulo ENTRIES.
- Each byte goes to the UART transmitter with a `trmt`/`tx_done` handshake.
- Sits between the sample RAM read port, the UART TX and `cmd_cfg`.

---
 rtl/dump_pkg.sv | 27 ++
 rtl/circ_addr_ctr.sv | 54 +++++
 rtl/dump_cntrl.sv | 180 ++++++++++++++++++
 tb/tb_dump_cntrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dump_pkg
//  Description : Shared types and default sizing for the sample-RAM dump
//                controller. Holds the controller state encoding and the
//                default RAM depth / address width.
//  Optional    : DUMP_CHKSUM_EN (adds the CHK state; the encoding always
//                reserves it so both builds share one type)
//  Revision    : 1.0 - initial release
// ============================================================================
package dump_pkg;

    localparam int ENTRIES_DEF = 384;   // sample RAM depth
    localparam int LOG2_DEF    = 9;     // address width, 2**LOG2 >= ENTRIES

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        WAIT  = 3'd4,
        CHK   = 3'd5,
        DONE  = 3'd6
    } state_t;

endpackage : dump_pkg
`default_nettype wire

// File: rtl/circ_addr_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : circ_addr_ctr
//  Description : Loadable circular address counter. Counts modulo ENTRIES
//                (ENTRIES-1 wraps to 0). A load value outside the RAM range
//                is replaced by 0 so the counter never leaves 0..ENTRIES-1.
//  Ports       : clk        - system clock
//                rst_n      - asynchronous active-low reset (addr -> 0)
//                load_i     - load load_val_i (has priority over inc_i)
//                load_val_i - value to load
//                inc_i      - advance by one, wrapping at ENTRIES-1
//                addr_o     - registered address
//  Revision    : 1.0 - initial release
// ============================================================================
module circ_addr_ctr #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [LOG2-1:0] load_val_i,
    input  logic            inc_i,
    output logic [LOG2-1:0] addr_o
);

    // Compared against LAST_IDX rather than ENTRIES so the comparison still
    // works when ENTRIES == 2**LOG2 (ENTRIES itself would not fit in LOG2 bits).
    localparam logic [LOG2-1:0] LAST_IDX = LOG2'(ENTRIES - 1);

    logic [LOG2-1:0] addr_q;
    logic [LOG2-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = (load_val_i > LAST_IDX) ? '0 : load_val_i;
        end else if (inc_i) begin
            addr_d = (addr_q == LAST_IDX) ? '0 : addr_q + LOG2'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule : circ_addr_ctr
`default_nettype wire

// File: rtl/dump_cntrl.sv
`default_nettype none
// ============================================================================
//  Module      : dump_cntrl
//  Description : Reader side of the capture sample RAM. On dump_en_i (in
//                IDLE) it reads every RAM entry once, oldest first, starting
//                at start_addr_i and wrapping modulo ENTRIES, and hands each
//                byte to the UART transmitter with a trmt/tx_done handshake.
//  Optional    : DUMP_CHKSUM_EN - append an 8-bit running sum of all sent
//                samples as one extra byte (ENTRIES+1 bytes per dump).
//  Ports       : clk          - system clock
//                rst_n        - asynchronous active-low reset
//                dump_en_i    - start pulse, sampled only in IDLE
//                start_addr_i - oldest sample location, sampled with dump_en_i
//                raddr_o      - registered RAM read address
//                re_o         - RAM read enable
//                rdata_i      - RAM read data, valid the cycle after re_o
//                tx_data_o    - registered byte to UART TX
//                trmt_o       - one-cycle transmit request
//                tx_done_i    - UART TX byte-complete pulse
//                dumping_o    - high in every state except IDLE
//                dump_done_o  - one-cycle pulse at end of dump
//  Revision    : 1.0 - initial release
// ============================================================================
module dump_cntrl
    import dump_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int LOG2    = LOG2_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dump_en_i,
    input  logic [LOG2-1:0] start_addr_i,
    output logic [LOG2-1:0] raddr_o,
    output logic            re_o,
    input  logic [7:0]      rdata_i,
    output logic [7:0]      tx_data_o,
    output logic            trmt_o,
    input  logic            tx_done_i,
    output logic            dumping_o,
    output logic            dump_done_o
);

    localparam logic [LOG2-1:0] LAST_IDX = LOG2'(ENTRIES - 1);

    state_t          state_q;
    state_t          state_d;
    logic [LOG2-1:0] cnt_q;
    logic [LOG2-1:0] cnt_d;
    logic [7:0]      tx_data_q;
    logic [7:0]      tx_data_d;
    logic            addr_load;
    logic            addr_inc;

`ifdef DUMP_CHKSUM_EN
    logic [7:0]      sum_q;
    logic [7:0]      sum_d;
    logic            chk_sent_q;   // the byte in flight is the checksum
    logic            chk_sent_d;
`endif

    // Read address: loaded at dump start, advanced after each non-final byte.
    assign addr_load = (state_q == IDLE) && dump_en_i;
    assign addr_inc  = (state_q == WAIT) && tx_done_i && (cnt_q != LAST_IDX)
`ifdef DUMP_CHKSUM_EN
                       && !chk_sent_q
`endif
                       ;

    circ_addr_ctr #(
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2)
    ) u_raddr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (addr_load),
        .load_val_i (start_addr_i),
        .inc_i      (addr_inc),
        .addr_o     (raddr_o)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
`ifdef DUMP_CHKSUM_EN
        sum_d      = sum_q;
        chk_sent_d = chk_sent_q;
`endif
        case (state_q)
            IDLE: begin
                if (dump_en_i) begin
                    cnt_d   = '0;
`ifdef DUMP_CHKSUM_EN
                    sum_d      = 8'h00;
                    chk_sent_d = 1'b0;
`endif
                    state_d = READ;
                end
            end
            READ: begin
                state_d = LATCH;
            end
            LATCH: begin
                tx_data_d = rdata_i;
`ifdef DUMP_CHKSUM_EN
                sum_d     = sum_q + rdata_i;
`endif
                state_d   = SEND;
            end
            SEND: begin
                // tx_done_i here belongs to nothing we sent; ignore it.
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done_i) begin
`ifdef DUMP_CHKSUM_EN
                    if (chk_sent_q) begin
                        state_d = DONE;
                    end else if (cnt_q == LAST_IDX) begin
                        state_d = CHK;
                    end else begin
                        cnt_d   = cnt_q + LOG2'(1);
                        state_d = READ;
                    end
`else
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + LOG2'(1);
                        state_d = READ;
                    end
`endif
                end
            end
`ifdef DUMP_CHKSUM_EN
            CHK: begin
                tx_data_d  = sum_q;
                chk_sent_d = 1'b1;
                state_d    = SEND;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tx_data_q <= 8'h00;
`ifdef DUMP_CHKSUM_EN
            sum_q      <= 8'h00;
            chk_sent_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
`ifdef DUMP_CHKSUM_EN
            sum_q      <= sum_d;
            chk_sent_q <= chk_sent_d;
`endif
        end
    end

    // Moore output decode
    assign re_o        = (state_q == READ);
    assign trmt_o      = (state_q == SEND);
    assign dump_done_o = (state_q == DONE);
    assign dumping_o   = (state_q != IDLE);
    assign tx_data_o   = tx_data_q;

endmodule : dump_cntrl
`default_nettype wire

// File: tb/tb_dump_cntrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dump_cntrl
//  Description : Self-checking bench for dump_cntrl (ENTRIES=384). A RAM and
//                UART TX responder surround the DUT; a reference model builds
//                the expected address/byte sequence for each accepted dump and
//                a compare process checks the DUT every cycle. Honours
//                DUMP_CHKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dump_cntrl;

    localparam int ENT = 384;
    localparam int LG  = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dump_en = 1'b0;
    logic [LG-1:0] start_addr = '0;
    logic [LG-1:0] raddr;
    logic          re;
    logic [7:0]    rdata = 8'h00;
    logic [7:0]    tx_data;
    logic          trmt;
    logic          tx_done = 1'b0;
    logic          dumping;
    logic          dump_done;

    dump_cntrl #(.ENTRIES(ENT), .LOG2(LG)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dump_en_i    (dump_en),
        .start_addr_i (start_addr),
        .raddr_o      (raddr),
        .re_o         (re),
        .rdata_i      (rdata),
        .tx_data_o    (tx_data),
        .trmt_o       (trmt),
        .tx_done_i    (tx_done),
        .dumping_o    (dumping),
        .dump_done_o  (dump_done)
    );

    always #5 clk = ~clk;

    // ---------------- RAM model: data valid the cycle after re ----------------
    logic [7:0] mem [0:511];
    always @(posedge clk) if (re) rdata <= mem[raddr];

    // ---------------- check bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    bit         exp_busy = 0;
    int         exp_addr[$];
    logic [7:0] exp_byte[$];
    bit         waiting = 0;
    logic [7:0] held = 8'h00;
    int         sent = 0;
    int         dumps = 0;
    bit         spur_en = 0;
    bit         hold_next = 0;

    // ---------------- UART TX responder ----------------
    initial begin : uart
        int  ucnt;
        int  spur;
        bit  t;
        bit  r;
        ucnt = 0;
        spur = 0;
        forever begin
            @(negedge clk);
            t = trmt;
            r = re;
            @(posedge clk);
            #2;
            tx_done = 1'b0;
            if (!rst_n) begin
                ucnt = 0;
                spur = 0;
            end else begin
                // stray pulse landing in the SEND cycle (two cycles after READ)
                if (spur > 0) begin
                    spur--;
                    if (spur == 0) tx_done = 1'b1;
                end
                if (r && spur_en && $urandom_range(0, 3) == 0) spur = 1;
                if (t) begin
                    ucnt = hold_next ? 500 : int'($urandom_range(1, 8));
                    hold_next = 0;
                end else if (ucnt > 0) begin
                    ucnt--;
                    if (ucnt == 0) tx_done = 1'b1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin : compare
        bit accept;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk({raddr, re, tx_data, trmt, dumping, dump_done} == 21'd0, "reset_outputs",
                    {raddr, re, tx_data, trmt, dumping, dump_done}, 0);
                exp_busy = 0;
                exp_addr.delete();
                exp_byte.delete();
                waiting = 0;
            end else begin
                accept = dump_en && !exp_busy;
                chk(dumping == exp_busy, "dumping", dumping, exp_busy);
                if (!exp_busy) begin
                    chk({re, trmt, dump_done} == 3'b000, "idle_quiet", {re, trmt, dump_done}, 0);
                end else begin
                    if (waiting && !trmt)
                        chk(tx_data == held, "tx_data_hold", tx_data, held);
                    if (waiting && tx_done) waiting = 0;
                    if (re) begin
                        if (exp_addr.size() == 0) chk(0, "extra_read", raddr, 0);
                        else begin
                            int a;
                            a = exp_addr.pop_front();
                            chk(raddr == LG'(a), "raddr", raddr, a);
                        end
                    end
                    if (trmt) begin
                        if (exp_byte.size() == 0) chk(0, "extra_trmt", tx_data, 0);
                        else begin
                            logic [7:0] b;
                            b = exp_byte.pop_front();
                            chk(tx_data == b, "tx_byte", tx_data, b);
                        end
                        held    = tx_data;
                        waiting = 1;
                        sent++;
                    end
                    if (dump_done) begin
                        chk(exp_addr.size() == 0 && exp_byte.size() == 0 && !waiting,
                            "done_early", exp_byte.size(), 0);
                        exp_busy = 0;
                        dumps++;
                    end
                end
                if (accept) begin
                    int         a0;
                    logic [7:0] sum;
                    a0  = (int'(start_addr) >= ENT) ? 0 : int'(start_addr);
                    sum = 8'h00;
                    exp_addr.delete();
                    exp_byte.delete();
                    for (int i = 0; i < ENT; i++) begin
                        int a;
                        a = (a0 + i) % ENT;
                        exp_addr.push_back(a);
                        exp_byte.push_back(mem[a]);
                        sum = sum + mem[a];
                    end
`ifdef DUMP_CHKSUM_EN
                    exp_byte.push_back(sum);
`endif
                    exp_busy = 1;
                    waiting  = 0;
                    sent     = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Starts a dump and pins the latency plus the first address/byte literally.
    task automatic start_dump(input logic [LG-1:0] a, input logic [LG-1:0] lit_addr,
                              input logic [7:0] lit_byte);
        @(posedge clk); #1;
        dump_en    = 1'b1;
        start_addr = a;
        @(posedge clk); #1;
        dump_en    = 1'b0;
        start_addr = LG'($urandom);
        @(negedge clk);
        chk(re == 1'b1, "lat_re", re, 1);
        chk(raddr == lit_addr, "first_raddr", raddr, lit_addr);
        @(negedge clk);
        chk({re, trmt} == 2'b00, "lat_latch", {re, trmt}, 0);
        @(negedge clk);
        chk(trmt == 1'b1, "lat_trmt", trmt, 1);
        chk(tx_data == lit_byte, "first_byte", tx_data, lit_byte);
    endtask

    task automatic wait_done(input bit repulse);
        int n;
        int d0;
        n  = 0;
        d0 = dumps;
        forever begin
            @(posedge clk); #1;
            if (repulse && exp_busy && $urandom_range(0, 39) == 0) begin
                dump_en    = 1'b1;
                start_addr = LG'($urandom);
            end else begin
                dump_en = 1'b0;
            end
            if (!exp_busy || n > 20000) break;
            n++;
        end
        dump_en = 1'b0;
        chk(!exp_busy, "dump_timeout", n, 0);
        chk(dumps == d0 + 1, "dump_count", dumps, d0 + 1);
    endtask

    task automatic rand_dump();
        logic [LG-1:0] a;
        logic [LG-1:0] a0;
        a  = LG'($urandom);
        a0 = (int'(a) >= ENT) ? '0 : a;
        start_dump(a, a0, mem[a0]);
        wait_done(1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int d0;
        int n;
        for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'hA5;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // oldest sample at 0; first byte held 500 cycles by the UART
        hold_next = 1;
        start_dump(9'd0, 9'd0, 8'hA5);
        wait_done(1'b1);

        // wrap-around: 380..383 then 0..379
        start_dump(9'd380, 9'd380, 8'hD9);
        wait_done(1'b1);

        // out-of-range start address falls back to 0
        spur_en = 1;
        start_dump(9'd400, 9'd0, 8'hA5);
        wait_done(1'b1);

        // reset during WAIT aborts the dump without dump_done
        d0 = dumps;
        start_dump(9'd100, 9'd100, 8'hC1);
        n = 0;
        while (sent < 3 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(sent >= 3, "abort_progress", sent, 3);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        chk(dumps == d0, "abort_no_done", dumps, d0);
        start_dump(9'd100, 9'd100, 8'hC1);
        wait_done(1'b1);

        // fresh random contents, random start addresses
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        repeat (2) rand_dump();

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dump_cntrl
`default_nettype wire
